demux_1ton: RTL and testbench

Registered 1-to-N demultiplexer and serial-to-parallel deserializer: the receive-side counterpart of the team's N-to-1 select mux. In addressed mode it steers one input bit to the lane named by `select`. In sequential mode an internal lane pointer scans 0..N-1, so a bit stream serialized by a counter-driven N-to-1 mux is rebuilt into an N-bit word and delivered over a valid/ready handshake.

---
 rtl/demux_pkg.sv | 20 ++
 rtl/lane_decoder.sv | 25 ++
 rtl/demux_1ton.sv | 119 +++++++++++
 tb/tb_demux_1ton.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the 1-to-N demux / deserializer
//
// Contents:
//   mode_e        addressed (MODE_ADDR) vs sequential (MODE_SEQ) operation
//   DEFAULT_SEL   default select/pointer width
//   onehot_width  number of one-hot lanes addressed by a SEL-bit index
package demux_pkg;

    typedef enum logic {
        MODE_ADDR = 1'b0,
        MODE_SEQ  = 1'b1
    } mode_e;

    localparam int DEFAULT_SEL = 3;

    function automatic int onehot_width(input int sel_bits);
        return 1 << sel_bits;
    endfunction

endpackage

// File: rtl/lane_decoder.sv
// rtl/lane_decoder.sv - SEL-to-N one-hot decoder with enable
//
// Ports:
//   en      in  1    decoder enable; output is all-zero when low
//   sel     in  SEL  lane index
//   onehot  out N    one-hot lane vector (bit sel set when en)
module lane_decoder
    import demux_pkg::*;
#(
    parameter int SEL = DEFAULT_SEL,
    parameter int N   = onehot_width(SEL)
) (
    input  logic           en,
    input  logic [SEL-1:0] sel,
    output logic [N-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_1ton.sv
// rtl/demux_1ton.sv - registered 1-to-N demultiplexer and serial-to-parallel deserializer
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   mode         0 = addressed, 1 = sequential
//   select       target lane in addressed mode
//   in/in_valid/in_ready   serial bit input with handshake
//   out          registered lane bits
//   lane_wr      one-hot marker of the lane written by the previous accept
//   ptr          sequential lane pointer
//   word/word_valid/word_ready   completed sequential word with handshake
module demux_1ton
    import demux_pkg::*;
#(
    parameter int SEL = DEFAULT_SEL,
    parameter int N   = onehot_width(SEL)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SEL-1:0] select,
    input  logic           in,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N-1:0]   out,
    output logic [N-1:0]   lane_wr,
    output logic [SEL-1:0] ptr,
    output logic [N-1:0]   word,
    output logic           word_valid,
    input  logic           word_ready
);

    localparam logic [SEL-1:0] LAST_LANE = SEL'(N - 1);

    mode_e          mode_q;
    mode_e          mode_nxt;
    logic           mode_change;
    logic           accept;
    logic           complete;
    logic [SEL-1:0] lane_sel;
    logic [N-1:0]   wr_onehot;

    assign mode_change = (mode != mode_q);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= mode_e'(mode);
        end else begin
            mode_q <= mode_nxt;
        end
    end

    // FSM: next state and input handshake. A pending mode switch blocks
    // input for that cycle so no bit lands in a frame about to be dropped.
    always_comb begin
        mode_nxt = mode_q;
        in_ready = 1'b0;
        case (mode_q)
            MODE_ADDR: in_ready = 1'b1;
            MODE_SEQ:  in_ready = (ptr != LAST_LANE) || !word_valid || word_ready;
            default:   in_ready = 1'b0;
        endcase
        if (mode_change) begin
            mode_nxt = mode_e'(mode);
            in_ready = 1'b0;
        end
    end

    assign accept   = in_valid && in_ready;
    assign lane_sel = (mode_q == MODE_SEQ) ? ptr : select;
    assign complete = accept && (mode_q == MODE_SEQ) && (ptr == LAST_LANE);

    lane_decoder #(
        .SEL (SEL),
        .N   (N)
    ) u_lane_decoder (
        .en     (accept),
        .sel    (lane_sel),
        .onehot (wr_onehot)
    );

    // Lane register bank and write marker
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out     <= '0;
            lane_wr <= '0;
        end else begin
            out     <= (out & ~wr_onehot) | (in ? wr_onehot : '0);
            lane_wr <= wr_onehot;
        end
    end

    // Sequential lane pointer; wraps naturally because N == 2**SEL
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (mode_change) begin
            ptr <= '0;
        end else if (accept && (mode_q == MODE_SEQ)) begin
            ptr <= ptr + SEL'(1);
        end
    end

    // Word register: the completing bit bypasses out so the word is
    // available right after the edge that accepts lane N-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word       <= '0;
            word_valid <= 1'b0;
        end else if (complete) begin
            word       <= {in, out[N-2:0]};
            word_valid <= 1'b1;
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux_1ton.sv
// tb/tb_demux_1ton.sv - self-checking bench for demux_1ton with a word scoreboard
module tb_demux_1ton;

    localparam int SEL = 3;
    localparam int N   = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mode;
    logic [SEL-1:0] select;
    logic           in;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   out;
    logic [N-1:0]   lane_wr;
    logic [SEL-1:0] ptr;
    logic [N-1:0]   word;
    logic           word_valid;
    logic           word_ready;

    int total = 0;
    int bad   = 0;
    int words_seen = 0;
    bit rand_rdy = 1'b0;
    logic [7:0] exp_q[$];

    demux_1ton #(.SEL(SEL), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .select     (select),
        .in         (in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out),
        .lane_wr    (lane_wr),
        .ptr        (ptr),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at negedge, pop the scoreboard on a
    // consumed word, then return 1 time unit after the rising edge.
    task automatic tick(output bit acc);
        bit fire;
        logic [7:0] w;
        if (rand_rdy) word_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc  = in_valid && in_ready;
        fire = word_valid && word_ready;
        w    = word;
        if (fire) begin
            words_seen++;
            if (exp_q.size() == 0) check("unexpected_word", 32'(w), 32'hFFFF_FFFF);
            else check("word", 32'(w), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        bit a;
        tick(a);
    endtask

    task automatic send_bit(input logic b);
        bit a;
        bit done;
        done = 1'b0;
        in = b;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            tick(a);
            if (a) done = 1'b1;
        end
        if (!done) check("accept_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        exp_q.push_back(v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    initial begin
        logic [7:0] rv;
        rst_n = 1'b0; mode = 1'b0; select = '0; in = 1'b0; in_valid = 1'b0; word_ready = 1'b0;
        #1;
        step(); step();
        rst_n = 1'b1;
        check("rst_out",     32'(out), 32'h00);
        check("rst_lane_wr", 32'(lane_wr), 32'h00);
        check("rst_ptr",     32'(ptr), 32'h0);
        check("rst_word",    32'(word), 32'h00);
        check("rst_wvalid",  32'(word_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // addressed write
        select = 3'd5; in = 1'b1; in_valid = 1'b1;
        step();
        check("addr_out", 32'(out), 32'h20);
        check("addr_lane_wr", 32'(lane_wr), 32'h20);
        in_valid = 1'b0;
        step();
        check("addr_lane_wr_idle", 32'(lane_wr), 32'h00);
        check("addr_out_hold", 32'(out), 32'h20);
        in = 1'b0; in_valid = 1'b1;
        step();
        check("addr_out_clear", 32'(out), 32'h00);
        in_valid = 1'b0;

        // sequential frame
        mode = 1'b1;
        #1;
        check("modechg_in_ready", 32'(in_ready), 32'h0);
        step();
        check("seq_ptr_start", 32'(ptr), 32'h0);
        word_ready = 1'b1;
        send_byte(8'h4D);
        check("seq_wvalid", 32'(word_valid), 32'h1);
        check("seq_word", 32'(word), 32'h4D);
        check("seq_ptr_wrap", 32'(ptr), 32'h0);
        check("seq_lane_wr7", 32'(lane_wr), 32'h80);
        step();
        check("seq_wvalid_drop", 32'(word_valid), 32'h0);

        // backpressure
        word_ready = 1'b0;
        send_byte(8'h4D);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 7; i++) send_bit(8'hA5 >> i);
        check("bp_ptr", 32'(ptr), 32'h7);
        in = 1'b1; in_valid = 1'b1;
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'h0);
        check("bp_word_hold", 32'(word), 32'h4D);
        step();
        check("bp_in_ready_still_low", 32'(in_ready), 32'h0);
        word_ready = 1'b1;
        #1;
        check("bp_in_ready_release", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check("bp_word2", 32'(word), 32'hA5);
        check("bp_wvalid_stays", 32'(word_valid), 32'h1);
        step();
        check("bp_drained", 32'(word_valid), 32'h0);

        // mode switch mid-frame
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("ms_ptr3", 32'(ptr), 32'h3);
        mode = 1'b0; select = 3'd7; in = 1'b1; in_valid = 1'b1;
        #1;
        check("ms_in_ready", 32'(in_ready), 32'h0);
        step();
        in_valid = 1'b0;
        check("ms_ptr", 32'(ptr), 32'h0);
        check("ms_wvalid", 32'(word_valid), 32'h0);
        check("ms_lane_wr", 32'(lane_wr), 32'h00);
        check("ms_out", 32'(out), 32'hA3);

        // reset mid-frame with a pending word
        mode = 1'b1;
        step();
        word_ready = 1'b0;
        send_byte(8'h3C);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("rmf_ptr", 32'(ptr), 32'h4);
        check("rmf_wvalid", 32'(word_valid), 32'h1);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        exp_q.delete();
        check("rmf_out", 32'(out), 32'h00);
        check("rmf_lane_wr", 32'(lane_wr), 32'h00);
        check("rmf_ptr0", 32'(ptr), 32'h0);
        check("rmf_word", 32'(word), 32'h00);
        check("rmf_wvalid0", 32'(word_valid), 32'h0);
        word_ready = 1'b1;
        send_byte(8'hC6);
        check("rmf_clean_word", 32'(word), 32'hC6);
        step();

        // wrap stress with random downstream readiness
        words_seen = 0;
        rand_rdy = 1'b1;
        for (int f = 0; f < 8; f++) begin
            rv = 8'($urandom_range(0, 255));
            send_byte(rv);
        end
        rand_rdy = 1'b0;
        word_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || word_valid); i++) step();
        check("stress_queue_empty", 32'(exp_q.size()), 32'h0);
        check("stress_word_count", 32'(words_seen), 32'd8);
        check("stress_wvalid_idle", 32'(word_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
